// File: rtl/bcd_convert_sequencer.sv
// bcd_convert_sequencer: round-robin sharing of one binary-to-BCD converter between two requesters,
// with converter start sequencing, completion watchdog and a valid/ready result port.
module bcd_convert_sequencer #(
  parameter int TIMEOUT_CYCLES = 127,
  parameter int TMO_W          = 7
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req0_valid_i,
  input  logic [31:0] req0_value_i,
  output logic        req0_ready_o,
  input  logic        req1_valid_i,
  input  logic [31:0] req1_value_i,
  output logic        req1_ready_o,
  output logic [31:0] conv_number_o,
  output logic        conv_start_o,
  input  logic        conv_complete_i,
  input  logic [39:0] conv_digits_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic        res_id_o,
  output logic [39:0] res_bcd_o,
  output logic [3:0]  res_msd_o,
  output logic        res_timeout_o,
  output logic        busy_o
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DELIVER} state_t;
  state_t state, state_nxt;
  logic rr, g0, g1, take, finish, tmo_hit;
  logic [TMO_W-1:0] cnt;
  logic [3:0] msd_nxt;
  // rr names the requester preferred on the next tie
  assign g0      = req0_valid_i & (~req1_valid_i | ~rr);
  assign g1      = req1_valid_i & (~req0_valid_i | rr);
  assign take    = (state == IDLE) & (g0 | g1);
  assign tmo_hit = cnt == TMO_W'(TIMEOUT_CYCLES - 1);
  assign finish  = (state == RUN) & (conv_complete_i | tmo_hit);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (take ? LOAD : IDLE) :
                state == LOAD ? RUN :
                state == RUN  ? (finish ? DELIVER : RUN) :
                                (res_ready_i ? IDLE : DELIVER);
  always_comb begin
    req0_ready_o = (state == IDLE) & g0;
    req1_ready_o = (state == IDLE) & g1;
    conv_start_o = state == RUN;
    res_valid_o  = state == DELIVER;
    busy_o       = state != IDLE;
  end
  always_comb begin
    msd_nxt = '0;
    for (int i = 0; i < 10; i++)
      if (conv_digits_i[4*i +: 4] != 4'd0) msd_nxt = 4'(i);
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      rr            <= 1'b0;
      conv_number_o <= '0;
      res_id_o      <= 1'b0;
      cnt           <= '0;
      res_bcd_o     <= '0;
      res_msd_o     <= '0;
      res_timeout_o <= 1'b0;
    end else begin
      cnt <= state == RUN ? cnt + 1'b1 : '0;
      if (take) begin
        conv_number_o <= g0 ? req0_value_i : req1_value_i;
        res_id_o      <= ~g0;
        rr            <= g0;
      end
      // a completion in the watchdog's last cycle still counts as success
      if (finish) begin
        res_bcd_o     <= conv_complete_i ? conv_digits_i : '0;
        res_msd_o     <= conv_complete_i ? msd_nxt : '0;
        res_timeout_o <= ~conv_complete_i;
      end
    end
endmodule

// File: tb/tb_bcd_convert_sequencer.sv
// tb_bcd_convert_sequencer: directed checks of arbitration, sequencing, watchdog and reset,
// with a behavioural converter that completes a fixed number of cycles after start.
module tb_bcd_convert_sequencer;
  localparam int LAT = 34;
  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0, res_ready_i = 1'b0;
  logic [31:0] req0_value_i = '0, req1_value_i = '0;
  logic        req0_ready_o, req1_ready_o, conv_start_o, conv_complete_i;
  logic [31:0] conv_number_o;
  logic [39:0] conv_digits_i, res_bcd_o;
  logic        res_valid_o, res_id_o, res_timeout_o, busy_o;
  logic [3:0]  res_msd_o;
  logic        stub_ok = 1'b1;
  int          cc = 0;
  int          n_assert = 0, n_fail = 0;

  bcd_convert_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req0_valid_i(req0_valid_i), .req0_value_i(req0_value_i), .req0_ready_o(req0_ready_o),
    .req1_valid_i(req1_valid_i), .req1_value_i(req1_value_i), .req1_ready_o(req1_ready_o),
    .conv_number_o(conv_number_o), .conv_start_o(conv_start_o),
    .conv_complete_i(conv_complete_i), .conv_digits_i(conv_digits_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_id_o(res_id_o),
    .res_bcd_o(res_bcd_o), .res_msd_o(res_msd_o), .res_timeout_o(res_timeout_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [39:0] to_bcd(input logic [31:0] v);
    logic [39:0] r;
    logic [31:0] x;
    r = '0;
    x = v;
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  always @(posedge clk_i) cc <= conv_start_o ? cc + 1 : 0;
  assign conv_complete_i = stub_ok & conv_start_o & (cc >= LAT);
  assign conv_digits_i   = conv_complete_i ? to_bcd(conv_number_o) : '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic idx, input logic [31:0] v, input string tag);
    @(negedge clk_i);
    if (idx) begin req1_valid_i = 1'b1; req1_value_i = v; end
    else begin req0_valid_i = 1'b1; req0_value_i = v; end
    #1 chk({tag, " ready"}, {req1_ready_o, req0_ready_o}, idx ? 2'b10 : 2'b01);
    @(negedge clk_i);
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    chk({tag, " load"}, {busy_o, conv_start_o}, 2'b10);
  endtask

  task automatic wait_res(input string tag);
    int k = 0;
    while (!res_valid_o && k < 400) begin
      @(negedge clk_i);
      k++;
    end
    chk({tag, " res_valid"}, res_valid_o, 1'b1);
  endtask

  task automatic ack(input string tag);
    res_ready_i = 1'b1;
    @(negedge clk_i);
    res_ready_i = 1'b0;
    chk({tag, " ack"}, {res_valid_o, busy_o}, 2'b00);
  endtask

  initial begin
    logic [3:0] gid, rid;
    int ng, nr, k, runc;
    logic prev_g;
    repeat (3) @(negedge clk_i);
    chk("reset outputs", {req0_ready_o, req1_ready_o, conv_start_o, res_valid_o, res_id_o,
        res_timeout_o, busy_o, res_msd_o}, '0);
    chk("reset data", {res_bcd_o, conv_number_o}, '0);
    rst_ni = 1'b1;

    send(1'b0, 32'd12345678, "t1");
    wait_res("t1");
    chk("t1 bcd", res_bcd_o, 40'h0012345678);
    chk("t1 msd/id/tmo", {res_msd_o, res_id_o, res_timeout_o}, {4'd7, 1'b0, 1'b0});
    ack("t1");

    send(1'b1, 32'hFFFFFFFF, "t2");
    wait_res("t2");
    chk("t2 bcd", res_bcd_o, 40'h4294967295);
    chk("t2 msd/id/tmo", {res_msd_o, res_id_o, res_timeout_o}, {4'd9, 1'b1, 1'b0});
    ack("t2");

    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    req0_valid_i = 1'b1; req0_value_i = 32'd11;
    req1_valid_i = 1'b1; req1_value_i = 32'd22;
    res_ready_i = 1'b1;
    gid = '0; rid = '0; ng = 0; nr = 0; k = 0; prev_g = 1'b0;
    while (nr < 4 && k < 2000) begin
      #1;
      if (prev_g) chk("t3 ready pulse", {req0_ready_o, req1_ready_o}, 2'b00);
      prev_g = req0_ready_o | req1_ready_o;
      if (prev_g) begin
        chk("t3 single grant", req0_ready_o & req1_ready_o, 1'b0);
        if (ng < 4) gid[ng] = req1_ready_o;
        ng++;
      end
      if (res_valid_o) begin
        chk("t3 bcd", res_bcd_o, res_id_o ? 40'h22 : 40'h11);
        rid[nr] = res_id_o;
        nr++;
        if (nr == 4) begin req0_valid_i = 1'b0; req1_valid_i = 1'b0; end
      end
      @(negedge clk_i);
      k++;
    end
    res_ready_i = 1'b0;
    chk("t3 result count", nr, 4);
    chk("t3 grant order", gid, 4'b1010);
    chk("t3 result order", rid, 4'b1010);
    chk("t3 idle", busy_o, 1'b0);

    send(1'b0, 32'd99, "t4");
    wait_res("t4");
    req0_valid_i = 1'b1;
    req1_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1 chk("t4 hold", {res_valid_o, req0_ready_o, req1_ready_o, conv_start_o, res_msd_o,
                         res_id_o, res_timeout_o, res_bcd_o},
             {1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 40'h99});
      @(negedge clk_i);
    end
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    ack("t4");

    stub_ok = 1'b0;
    send(1'b1, 32'd5, "t5");
    runc = 0; k = 0;
    while (!res_valid_o && k < 400) begin
      if (conv_start_o) runc++;
      @(negedge clk_i);
      k++;
    end
    chk("t5 res_valid", res_valid_o, 1'b1);
    chk("t5 run cycles", runc, 127);
    chk("t5 tmo/msd/id", {res_timeout_o, res_msd_o, res_id_o}, {1'b1, 4'd0, 1'b1});
    chk("t5 bcd", res_bcd_o, 40'h0);
    ack("t5");
    stub_ok = 1'b1;

    send(1'b1, 32'd777, "t6");
    repeat (10) @(negedge clk_i);
    chk("t6 running", conv_start_o, 1'b1);
    rst_ni = 1'b0;
    #1 chk("t6 reset outputs", {conv_start_o, res_valid_o, busy_o, res_id_o, res_timeout_o,
                                res_msd_o}, '0);
    chk("t6 reset data", {res_bcd_o, conv_number_o}, '0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    send(1'b0, 32'd0, "t6b");
    wait_res("t6b");
    chk("t6 bcd", res_bcd_o, 40'h0);
    chk("t6 msd/id/tmo", {res_msd_o, res_id_o, res_timeout_o}, {4'd0, 1'b0, 1'b0});
    ack("t6b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "time limit");
  end
endmodule
